// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_schedule (with helper aes_sbox)
//  Purpose  : Sequential AES-128 key expansion. On start, emits round keys
//             0..10 in order, one rk_valid pulse each. SubWord is computed one
//             byte per cycle through a single shared S-box.
//  Ports    : clk       - rising-edge clock
//             rst       - asynchronous active-high reset
//             start     - request expansion (sampled only when idle)
//             key_in    - 128-bit cipher key, byte 0 = key_in[127:120]
//             busy      - expansion in progress
//             rk_valid  - one-cycle pulse, round_key/rk_index valid
//             rk_index  - round number 0..10 of round_key
//             round_key - current round key
//             done      - one-cycle pulse with the round-10 key
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  aes_sbox : combinational AES forward S-box built from the GF(2^8)
//  multiplicative inverse (x^254) followed by the affine transform.
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv  = gf_inv(i_byte);
        o_byte = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
    end

endmodule

// ----------------------------------------------------------------------------
//  aes_key_schedule : top
// ----------------------------------------------------------------------------
module aes_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_EXP  = 2'd2
    } state_t;

    state_t         state_q,     state_d;
    logic [1:0]     byte_cnt_q,  byte_cnt_d;
    logic [7:0]     rcon_q,      rcon_d;
    logic [31:0]    sub_q,       sub_d;
    logic [127:0]   round_key_q, round_key_d;
    logic [3:0]     rk_index_q,  rk_index_d;
    logic           rk_valid_q,  rk_valid_d;
    logic           busy_q,      busy_d;
    logic           done_q,      done_d;

    logic [31:0]    w_w3;
    logic [1:0]     w_sel;
    logic [7:0]     w_sbox_in;
    logic [7:0]     w_sbox_out;
    logic [31:0]    w_t;
    logic [31:0]    w_w0n, w_w1n, w_w2n, w_w3n;
    logic [7:0]     w_rcon_next;

    // RotWord folded into the byte select: cycle k substitutes byte k+1 of w3.
    always_comb begin
        w_w3  = round_key_q[31:0];
        w_sel = byte_cnt_q + 2'd1;
        case (w_sel)
            2'd0:    w_sbox_in = w_w3[31:24];
            2'd1:    w_sbox_in = w_w3[23:16];
            2'd2:    w_sbox_in = w_w3[15:8];
            default: w_sbox_in = w_w3[7:0];
        endcase
    end

    aes_sbox u_sbox (
        .i_byte (w_sbox_in),
        .o_byte (w_sbox_out)
    );

    always_comb begin
        w_t         = sub_q ^ {rcon_q, 24'h000000};
        w_w0n       = round_key_q[127:96] ^ w_t;
        w_w1n       = round_key_q[95:64]  ^ w_w0n;
        w_w2n       = round_key_q[63:32]  ^ w_w1n;
        w_w3n       = round_key_q[31:0]   ^ w_w2n;
        w_rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        rcon_d      = rcon_q;
        sub_d       = sub_q;
        round_key_d = round_key_q;
        rk_index_d  = rk_index_q;
        busy_d      = busy_q;
        rk_valid_d  = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    round_key_d = key_in;
                    rk_index_d  = 4'd0;
                    rk_valid_d  = 1'b1;
                    busy_d      = 1'b1;
                    byte_cnt_d  = 2'd0;
                    rcon_d      = 8'h01;
                    state_d     = ST_SUB;
                end
            end
            ST_SUB: begin
                case (byte_cnt_q)
                    2'd0:    sub_d[31:24] = w_sbox_out;
                    2'd1:    sub_d[23:16] = w_sbox_out;
                    2'd2:    sub_d[15:8]  = w_sbox_out;
                    default: sub_d[7:0]   = w_sbox_out;
                endcase
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    state_d = ST_EXP;
                end
            end
            ST_EXP: begin
                round_key_d = {w_w0n, w_w1n, w_w2n, w_w3n};
                rk_index_d  = rk_index_q + 4'd1;
                rk_valid_d  = 1'b1;
                rcon_d      = w_rcon_next;
                if (rk_index_q == 4'd9) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    byte_cnt_d = 2'd0;
                    state_d    = ST_SUB;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= 2'd0;
            rcon_q      <= 8'h01;
            sub_q       <= 32'h0;
            round_key_q <= 128'h0;
            rk_index_q  <= 4'd0;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            rcon_q      <= rcon_d;
            sub_q       <= sub_d;
            round_key_q <= round_key_d;
            rk_index_q  <= rk_index_d;
            rk_valid_q  <= rk_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign rk_valid  = rk_valid_q;
    assign rk_index  = rk_index_q;
    assign round_key = round_key_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_key_schedule
//  Purpose  : Directed self-checking bench for aes_key_schedule using
//             FIPS-197 and all-zero key vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_key_schedule;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         done;

    int vectors;
    int miscompares;
    int pulse_cnt;
    int done_cnt;
    int busy_cnt;

    logic [127:0] fips_rk [0:10];
    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_index  (rk_index),
        .round_key (round_key),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse / busy bookkeeping, sampled on the inactive edge.
    initial begin
        pulse_cnt = 0;
        done_cnt  = 0;
        busy_cnt  = 0;
    end
    always @(negedge clk) begin
        if (rk_valid) pulse_cnt <= pulse_cnt + 1;
        if (done)     done_cnt  <= done_cnt + 1;
        if (busy)     busy_cnt  <= busy_cnt + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full expansion with start pulsed for one cycle; key_in is scrambled
    // right after acceptance. Full table for FIPS, rounds 1/10 for zero key.
    task automatic run_and_check(input logic [127:0] key, input logic is_fips);
        int p0, d0, b0;
        logic [127:0] exp;
        logic known;
        p0 = pulse_cnt; d0 = done_cnt; b0 = busy_cnt;
        key_in = key;
        start  = 1'b1;
        step();
        start  = 1'b0;
        key_in = ~key;
        check("r0_valid", {127'h0, rk_valid}, 128'h1);
        check("r0_index", {124'h0, rk_index}, 128'h0);
        check("r0_key",   round_key, key);
        check("r0_busy",  {127'h0, busy}, 128'h1);
        for (int n = 1; n <= 10; n++) begin
            repeat (5) step();
            check("rn_valid", {127'h0, rk_valid}, 128'h1);
            check("rn_index", {124'h0, rk_index}, 128'(n));
            known = 1'b1;
            if (is_fips)       exp = fips_rk[n];
            else if (n == 1)   exp = ZERO_R1;
            else if (n == 10)  exp = ZERO_R10;
            else begin
                exp   = 128'h0;
                known = 1'b0;
            end
            if (known) check("rn_key", round_key, exp);
            check("rn_done", {127'h0, done}, (n == 10) ? 128'h1 : 128'h0);
            check("rn_busy", {127'h0, busy}, (n == 10) ? 128'h0 : 128'h1);
        end
        step();
        check("post_valid", {127'h0, rk_valid}, 128'h0);
        check("post_done",  {127'h0, done}, 128'h0);
        check("post_hold",  round_key, is_fips ? fips_rk[10] : ZERO_R10);
        check("pulse_count", 128'(pulse_cnt - p0), 128'd11);
        check("done_count",  128'(done_cnt - d0), 128'd1);
        check("busy_cycles", 128'(busy_cnt - b0), 128'd50);
    endtask

    initial begin
        int p0;
        vectors     = 0;
        miscompares = 0;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst    = 1'b1;
        start  = 1'b0;
        key_in = 128'h0;
        step();
        step();
        check("rst_busy",  {127'h0, busy}, 128'h0);
        check("rst_valid", {127'h0, rk_valid}, 128'h0);
        check("rst_done",  {127'h0, done}, 128'h0);
        check("rst_index", {124'h0, rk_index}, 128'h0);
        check("rst_key",   round_key, 128'h0);
        rst = 1'b0;
        step();

        // FIPS-197 vector, single-cycle start
        run_and_check(FIPS_KEY, 1'b1);

        // start held high across two expansions; key_in changes mid-run
        key_in = 128'h0;
        start  = 1'b1;
        step();
        key_in = FIPS_KEY;
        check("hold_r0_index", {124'h0, rk_index}, 128'h0);
        check("hold_r0_key",   round_key, 128'h0);
        for (int n = 1; n <= 10; n++) begin
            repeat (5) step();
            check("hold_valid", {127'h0, rk_valid}, 128'h1);
            check("hold_index", {124'h0, rk_index}, 128'(n));
            if (n == 1)  check("hold_r1_key",  round_key, ZERO_R1);
            if (n == 10) check("hold_r10_key", round_key, ZERO_R10);
        end
        check("hold_done", {127'h0, done}, 128'h1);
        step();
        start = 1'b0;
        check("hold_restart_valid", {127'h0, rk_valid}, 128'h1);
        check("hold_restart_index", {124'h0, rk_index}, 128'h0);
        check("hold_restart_key",   round_key, FIPS_KEY);

        // Async reset during SUB of round 4
        repeat (15) step();
        check("pre_rst_index", {124'h0, rk_index}, 128'd3);
        check("pre_rst_key",   round_key, fips_rk[3]);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",  {127'h0, busy}, 128'h0);
        check("arst_valid", {127'h0, rk_valid}, 128'h0);
        check("arst_done",  {127'h0, done}, 128'h0);
        check("arst_index", {124'h0, rk_index}, 128'h0);
        check("arst_key",   round_key, 128'h0);
        p0 = pulse_cnt;
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        check("arst_no_pulses", 128'(pulse_cnt - p0), 128'd0);
        check("arst_idle_busy", {127'h0, busy}, 128'h0);

        // Fresh FIPS run after reset, then zero key back-to-back
        run_and_check(FIPS_KEY, 1'b1);
        run_and_check(128'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
